// File: rtl/gtxe2_chnl_rx_align.sv
// GTXE2 RX comma detector and byte aligner: searches {in_data, prev} for K28.5
// commas at every bit offset, locks an offset and emits realigned words.
module gtxe2_chnl_rx_align #(
  parameter int         width      = 20,
  parameter logic [9:0] pcomma     = 10'b0101111100,
  parameter logic [9:0] mcomma     = 10'b1010000011,
  parameter logic [9:0] comma_mask = 10'b1111111111,
  parameter int         loss_limit = 256,
  localparam int        OW         = (width > 2) ? $clog2(width) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  input  logic [width-1:0] in_data,
  input  logic             pcommaalignen,
  input  logic             mcommaalignen,
  input  logic             realign_en,
  output logic             out_val,
  output logic [width-1:0] out_data,
  output logic             commadet,
  output logic             byteisaligned,
  output logic             byterealign,
  output logic [OW-1:0]    offset
);

  localparam int             LCW       = (loss_limit > 0) ? $clog2(loss_limit + 1) : 1;
  localparam logic [LCW-1:0] LOSS_MAX  = LCW'(loss_limit);
  localparam logic [LCW-1:0] LOSS_LAST = (loss_limit > 0) ? LCW'(loss_limit - 1) : '0;
  localparam logic [9:0]     PC_M      = pcomma & comma_mask;
  localparam logic [9:0]     MC_M      = mcomma & comma_mask;

  typedef enum logic [0:0] {
    ST_UNALIGNED = 1'b0,
    ST_ALIGNED   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      offset_q, offset_d;
  logic [LCW-1:0]     loss_q, loss_d;
  logic               realign_q, realign_d;
  logic [width-1:0]   prev_q;
  logic               out_val_q;
  logic [width-1:0]   out_data_q, out_data_d;
  logic               commadet_q;
  logic [2*width-1:0] win_s;
  logic               hit_s;
  logic [OW-1:0]      hit_k_s;

  assign win_s = {in_data, prev_q};

  // Comma search: scan from the top so the lowest matching offset is kept.
  always_comb begin
    hit_s   = 1'b0;
    hit_k_s = '0;
    for (int k = width - 1; k >= 0; k--) begin
      if ((pcommaalignen && ((win_s[k +: 10] & comma_mask) == PC_M)) ||
          (mcommaalignen && ((win_s[k +: 10] & comma_mask) == MC_M))) begin
        hit_s   = 1'b1;
        hit_k_s = OW'(k);
      end else begin
        hit_s   = hit_s;
        hit_k_s = hit_k_s;
      end
    end
  end

  // Alignment FSM next state, offset selection and loss ageing.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    loss_d    = loss_q;
    realign_d = 1'b0;
    if (in_val) begin
      case (state_q)
        ST_UNALIGNED: begin
          if (hit_s) begin
            offset_d = hit_k_s;
            state_d  = ST_ALIGNED;
            loss_d   = '0;
          end else begin
            offset_d = offset_q;
          end
        end
        ST_ALIGNED: begin
          if (hit_s) begin
            // Any comma proves the link is alive, even one we refuse to follow.
            loss_d = '0;
            if (realign_en && (hit_k_s != offset_q)) begin
              offset_d  = hit_k_s;
              realign_d = 1'b1;
            end else begin
              offset_d = offset_q;
            end
          end else if (loss_limit > 0) begin
            if (loss_q < LOSS_MAX) begin
              loss_d = loss_q + LCW'(1);
            end else begin
              loss_d = loss_q;
            end
            if (loss_q >= LOSS_LAST) begin
              state_d = ST_UNALIGNED;
            end else begin
              state_d = ST_ALIGNED;
            end
          end else begin
            loss_d = loss_q;
          end
        end
        default: begin
          state_d = ST_UNALIGNED;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // The word leaving this cycle uses the offset being chosen this cycle.
  always_comb begin
    out_data_d = win_s[offset_d +: width];
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_UNALIGNED;
      offset_q  <= '0;
      loss_q    <= '0;
      realign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      loss_q    <= loss_d;
      realign_q <= realign_d;
    end
  end

  // Data path registers; everything holds on idle cycles except out_val.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      commadet_q <= 1'b0;
    end else if (in_val) begin
      prev_q     <= in_data;
      out_val_q  <= 1'b1;
      out_data_q <= out_data_d;
      commadet_q <= hit_s;
    end else begin
      out_val_q  <= 1'b0;
    end
  end

  assign out_val       = out_val_q;
  assign out_data      = out_data_q;
  assign commadet      = commadet_q;
  assign byteisaligned = (state_q == ST_ALIGNED);
  assign byterealign   = realign_q;
  assign offset        = offset_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_align.sv
// Randomized bench for gtxe2_chnl_rx_align against a bit-stream reference model.
module tb_gtxe2_chnl_rx_align;
  localparam int         W    = 20;
  localparam int         LL   = 4;
  localparam logic [9:0] PC   = 10'b0101111100;
  localparam logic [9:0] MC   = 10'b1010000011;
  localparam logic [9:0] MASK = 10'b1111111111;

  logic         clk = 1'b0;
  logic         reset, in_val, pcommaalignen, mcommaalignen, realign_en;
  logic [W-1:0] in_data;
  logic         out_val, commadet, byteisaligned, byterealign;
  logic [W-1:0] out_data;
  logic [4:0]   offset;

  always #5 clk = ~clk;

  gtxe2_chnl_rx_align #(
    .width(W), .pcomma(PC), .mcomma(MC), .comma_mask(MASK), .loss_limit(LL)
  ) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_data(in_data),
    .pcommaalignen(pcommaalignen), .mcommaalignen(mcommaalignen),
    .realign_en(realign_en), .out_val(out_val), .out_data(out_data),
    .commadet(commadet), .byteisaligned(byteisaligned),
    .byterealign(byterealign), .offset(offset)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: every received bit since reset, in arrival order.
  bit           stream_q[$];
  int           m_words, m_off, m_loss;
  bit           m_locked;
  logic         exp_val, exp_det, exp_al, exp_re;
  logic [W-1:0] exp_data;
  int           exp_off;
  logic [W-1:0] txw [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".val"}, 32'(out_val), 32'(exp_val));
    check_eq({tag, ".data"}, 32'(out_data), 32'(exp_data));
    check_eq({tag, ".aligned"}, 32'(byteisaligned), 32'(exp_al));
    check_eq({tag, ".realign"}, 32'(byterealign), 32'(exp_re));
    check_eq({tag, ".offset"}, 32'(offset), 32'(exp_off));
    if (exp_val) check_eq({tag, ".det"}, 32'(commadet), 32'(exp_det));
  endtask

  // Window bit j of valid word n = stream bit (n-1)*W + j; before the stream, zeros.
  function automatic bit winbit(input int n, input int j);
    int idx;
    idx = (n - 1) * W + j;
    if (idx < 0) return 1'b0;
    return stream_q[idx];
  endfunction

  task automatic model_reset();
    stream_q.delete();
    m_words = 0; m_off = 0; m_loss = 0; m_locked = 1'b0;
    exp_val = 1'b0; exp_det = 1'b0; exp_al = 1'b0; exp_re = 1'b0;
    exp_data = '0; exp_off = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d);
    int n, hk;
    bit hit, rea;
    logic [9:0] s;
    if (!v) begin
      exp_val = 1'b0;
      exp_re  = 1'b0;
      return;
    end
    n = m_words;
    for (int b = 0; b < W; b++) stream_q.push_back(d[b]);
    m_words++;
    hit = 1'b0; hk = 0; rea = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (!hit) begin
        for (int i = 0; i < 10; i++) s[i] = winbit(n, k + i);
        if ((pcommaalignen && ((s & MASK) == (PC & MASK))) ||
            (mcommaalignen && ((s & MASK) == (MC & MASK)))) begin
          hit = 1'b1; hk = k;
        end
      end
    end
    if (!m_locked) begin
      if (hit) begin m_locked = 1'b1; m_off = hk; m_loss = 0; end
    end else if (hit) begin
      m_loss = 0;
      if (realign_en && hk != m_off) begin m_off = hk; rea = 1'b1; end
    end else if (LL > 0) begin
      if (m_loss < LL) m_loss++;
      if (m_loss == LL) m_locked = 1'b0;
    end
    for (int b = 0; b < W; b++) exp_data[b] = winbit(n, m_off + b);
    exp_val = 1'b1; exp_det = hit; exp_re = rea; exp_al = m_locked; exp_off = m_off;
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input string tag);
    in_val  = v;
    in_data = d;
    model_step(v, d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    for (int c = 0; c < ncyc; c++) begin
      in_val  = 1'b1;
      in_data = W'($urandom);
      @(negedge clk);
      check_all("rst_hold");
    end
    in_val = 1'b0;
    reset  = 1'b0;
  endtask

  // Alternating-pair words: runs of at most two equal bits, so never a comma.
  function automatic logic [W-1:0] man_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 2; i++) r[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic build(input int nw);
    for (int i = 0; i < nw; i++) txw[i] = man_word();
  endtask

  task automatic insert(input int pos, input logic [9:0] pat);
    int p;
    for (int i = 0; i < 10; i++) begin
      p = pos + i;
      txw[p / W][p % W] = pat[i];
    end
  endtask

  logic [W-1:0] a, b, d;
  logic [9:0]   pat;
  int           p;

  initial begin
    reset = 1'b1; in_val = 1'b0; in_data = '0;
    pcommaalignen = 1'b1; mcommaalignen = 1'b1; realign_en = 1'b1;
    do_reset(3);

    // No comma after reset: first word is the all-zero prev, then the previous word.
    a = man_word(); b = man_word();
    cycle(1'b1, a, "plain0");
    check_eq("plain0_zero", 32'(out_data), 32'd0);
    cycle(1'b1, b, "plain1");
    check_eq("plain1_prev", 32'(out_data), 32'(a));
    check_eq("plain1_unal", 32'(byteisaligned), 32'd0);

    // pcomma at stream bit 7.
    do_reset(1);
    build(4); insert(7, PC);
    cycle(1'b1, txw[0], "c7_w0");
    cycle(1'b1, txw[1], "c7_w1");
    check_eq("c7_off", 32'(offset), 32'd7);
    check_eq("c7_al", 32'(byteisaligned), 32'd1);
    check_eq("c7_det", 32'(commadet), 32'd1);
    check_eq("c7_pat", 32'(out_data[9:0]), 32'(PC));
    cycle(1'b1, txw[2], "c7_w2");
    cycle(1'b1, txw[3], "c7_w3");
    check_eq("c7_contig", 32'(out_data), 32'({txw[3][6:0], txw[2][19:7]}));

    // Comma spanning two words at bit 15; then mcomma with its enable off.
    do_reset(1);
    build(3); insert(15, PC);
    cycle(1'b1, txw[0], "c15_w0");
    check_eq("c15_nolock0", 32'(byteisaligned), 32'd0);
    cycle(1'b1, txw[1], "c15_w1");
    check_eq("c15_off", 32'(offset), 32'd15);
    check_eq("c15_al", 32'(byteisaligned), 32'd1);
    do_reset(1);
    mcommaalignen = 1'b0;
    build(3); insert(15, MC);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, txw[i], "m15");
      check_eq("m15_nolock", 32'(byteisaligned), 32'd0);
    end
    mcommaalignen = 1'b1;

    // Realign from offset 7 to 3, with and without realign_en.
    for (int r = 1; r >= 0; r--) begin
      do_reset(1);
      realign_en = (r != 0);
      build(6); insert(7, PC); insert(63, PC);
      for (int i = 0; i < 4; i++) cycle(1'b1, txw[i], "ra_pre");
      check_eq("ra_before", 32'(offset), 32'd7);
      cycle(1'b1, txw[4], "ra_w4");
      check_eq("ra_off", 32'(offset), (r != 0) ? 32'd3 : 32'd7);
      check_eq("ra_pulse", 32'(byterealign), 32'(r));
      cycle(1'b1, txw[5], "ra_w5");
      check_eq("ra_pulse_end", 32'(byterealign), 32'd0);
    end
    realign_en = 1'b1;

    // Loss of alignment after LL comma-free valid words; idles do not age.
    do_reset(1);
    build(6); insert(7, PC);
    cycle(1'b1, txw[0], "loss_w0");
    cycle(1'b1, txw[1], "loss_w1");
    for (int i = 2; i < 6; i++) begin
      cycle(1'b0, man_word(), "loss_idle");
      cycle(1'b0, man_word(), "loss_idle");
      cycle(1'b1, txw[i], "loss_w");
      check_eq("loss_al", 32'(byteisaligned), (i < 5) ? 32'd1 : 32'd0);
    end

    // Reset mid-lock drops alignment immediately; first word after uses offset 0.
    do_reset(1);
    build(3); insert(7, PC);
    cycle(1'b1, txw[0], "ml_w0");
    cycle(1'b1, txw[1], "ml_w1");
    check_eq("ml_locked", 32'(byteisaligned), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("ml_async_drop", 32'(byteisaligned), 32'd0);
    do_reset(1);
    cycle(1'b1, txw[2], "ml_after");
    check_eq("ml_after_zero", 32'(out_data), 32'd0);

    // Random traffic: toggling in_val, random enables and embedded commas.
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        pcommaalignen = ($urandom_range(0, 3) != 0);
        mcommaalignen = ($urandom_range(0, 3) != 0);
        realign_en    = ($urandom_range(0, 1) != 0);
      end
      d = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        p   = $urandom_range(0, W - 10);
        pat = ($urandom_range(0, 1) != 0) ? PC : MC;
        for (int i = 0; i < 10; i++) d[p + i] = pat[i];
      end
      if (c == 300) do_reset(2);
      cycle(($urandom_range(0, 2) != 0), d, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
